// File: rtl/mt_cache_lru_pkg.sv
// Shared types for the L1 LRU tracker: threading mode, thread count and the
// helper that maps a (mode, thread) pair onto its way range within a set.
package mt_cache_lru_pkg;

  localparam int unsigned THR_PER_CORE       = 2;
  localparam int unsigned THR_PER_CORE_WIDTH = 1;

  typedef enum logic {
    ModeSt = 1'b0,
    ModeMt = 1'b1
  } multithreading_mode_t;

  typedef struct packed {
    int unsigned lo;
    int unsigned hi;
  } way_range_t;

  // Inclusive way range owned by thread thr; ST mode owns the whole set.
  function automatic way_range_t way_range(input multithreading_mode_t     mode,
                                           input logic [THR_PER_CORE_WIDTH-1:0] thr,
                                           input int unsigned              ways_per_set,
                                           input int unsigned              ways_mt);
    way_range_t r;
    if (mode == ModeMt) begin
      r.lo = 32'(thr) * ways_mt;
      r.hi = r.lo + ways_mt - 1;
    end else begin
      r.lo = 0;
      r.hi = ways_per_set - 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lru_age_update.sv
// Next-age computation for one set: ways in the accessed way's partition that
// are younger than it age by one, and the accessed way becomes the youngest.
module lru_age_update
  import mt_cache_lru_pkg::*;
#(
  parameter int unsigned WAYS_PER_SET = 4,
  parameter int unsigned NUM_WAYS_MT  = 2,
  localparam int unsigned WAY_W       = $clog2(WAYS_PER_SET)
) (
  input  multithreading_mode_t                   mode_i,
  input  logic [WAY_W-1:0]                       way_i,
  input  logic [WAYS_PER_SET-1:0][WAY_W-1:0]     ages_i,
  output logic [WAYS_PER_SET-1:0][WAY_W-1:0]     ages_o
);

  logic [THR_PER_CORE_WIDTH-1:0] thr;
  way_range_t                    rng;
  logic [WAY_W-1:0]              old_age;

  // The owning thread follows from the way index alone.
  assign thr     = THR_PER_CORE_WIDTH'(32'(way_i) / NUM_WAYS_MT);
  assign rng     = way_range(mode_i, thr, WAYS_PER_SET, NUM_WAYS_MT);
  assign old_age = ages_i[way_i];

  always_comb begin
    ages_o = ages_i;
    for (int unsigned w = 0; w < WAYS_PER_SET; w++) begin
      if (w >= rng.lo && w <= rng.hi && ages_i[w] < old_age) begin
        ages_o[w] = ages_i[w] + WAY_W'(1);
      end
    end
    ages_o[way_i] = '0;
  end

endmodule

// File: rtl/mt_cache_lru.sv
// Per-set age-based LRU tracker with thread-partitioned victim selection and
// two chained update ports (hit first, then refill) per cycle.
module mt_cache_lru
  import mt_cache_lru_pkg::*;
#(
  parameter int unsigned NUM_SET      = 4,
  parameter int unsigned NUM_WAYS     = 16,
  parameter int unsigned NUM_WAYS_MT  = 2,
  parameter int unsigned WAYS_PER_SET = 4,
  localparam int unsigned SET_W       = (NUM_SET > 1) ? $clog2(NUM_SET) : 1,
  localparam int unsigned WAY_W       = $clog2(WAYS_PER_SET)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  multithreading_mode_t          mt_mode,
  input  logic [THR_PER_CORE_WIDTH-1:0] thread_id,
  input  logic                          victim_req,
  input  logic [SET_W-1:0]              victim_set,
  output logic [WAY_W-1:0]              victim_way,
  input  logic                          update_req,
  input  logic [SET_W-1:0]              update_set,
  input  logic [WAY_W-1:0]              update_way,
  input  logic                          update_req_mt,
  input  logic [SET_W-1:0]              update_set_mt,
  input  logic [WAY_W-1:0]              update_way_mt,
  input  logic [THR_PER_CORE_WIDTH-1:0] update_thread_mt
);

  if (NUM_WAYS != NUM_SET * WAYS_PER_SET) begin : g_bad_num_ways
    $error("NUM_WAYS must equal NUM_SET*WAYS_PER_SET");
  end
  if (NUM_WAYS_MT != WAYS_PER_SET / THR_PER_CORE) begin : g_bad_num_ways_mt
    $error("NUM_WAYS_MT must equal WAYS_PER_SET/THR_PER_CORE");
  end

  typedef logic [WAYS_PER_SET-1:0][WAY_W-1:0] set_ages_t;

  set_ages_t            ages_q [NUM_SET];
  set_ages_t            ages_hit [NUM_SET];
  set_ages_t            ages_d [NUM_SET];
  multithreading_mode_t mode_q;

  // The refill way already identifies its partition.
  logic unused_thread_mt;
  assign unused_thread_mt = ^update_thread_mt;

  logic      hit_en, fill_en;
  set_ages_t hit_in, hit_out, fill_in, fill_out;

  assign hit_en  = update_req && (32'(update_set) < NUM_SET);
  assign fill_en = update_req_mt && (32'(update_set_mt) < NUM_SET);
  assign hit_in  = ages_q[update_set];

  lru_age_update #(
    .WAYS_PER_SET (WAYS_PER_SET),
    .NUM_WAYS_MT  (NUM_WAYS_MT)
  ) u_hit_update (
    .mode_i (mode_q),
    .way_i  (update_way),
    .ages_i (hit_in),
    .ages_o (hit_out)
  );

  always_comb begin
    ages_hit = ages_q;
    if (hit_en) begin
      ages_hit[update_set] = hit_out;
    end
  end

  // Refill sees the state already advanced by the hit, so same-set pairs chain.
  assign fill_in = ages_hit[update_set_mt];

  lru_age_update #(
    .WAYS_PER_SET (WAYS_PER_SET),
    .NUM_WAYS_MT  (NUM_WAYS_MT)
  ) u_fill_update (
    .mode_i (mode_q),
    .way_i  (update_way_mt),
    .ages_i (fill_in),
    .ages_o (fill_out)
  );

  always_comb begin
    ages_d = ages_hit;
    if (fill_en) begin
      ages_d[update_set_mt] = fill_out;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode_q <= ModeSt;
      for (int unsigned s = 0; s < NUM_SET; s++) begin
        for (int unsigned w = 0; w < WAYS_PER_SET; w++) begin
          ages_q[s][w] <= WAY_W'(WAYS_PER_SET - 1 - w);
        end
      end
    end else begin
      mode_q <= mt_mode;
      ages_q <= ages_d;
    end
  end

  way_range_t       vic_rng;
  logic [WAY_W-1:0] best_age;
  logic             found;

  assign vic_rng = way_range(mt_mode, thread_id, WAYS_PER_SET, NUM_WAYS_MT);

  // Strict compare keeps the lowest index on ties.
  always_comb begin
    victim_way = '0;
    best_age   = '0;
    found      = 1'b0;
    if (victim_req && (32'(victim_set) < NUM_SET)) begin
      for (int unsigned w = 0; w < WAYS_PER_SET; w++) begin
        if (w >= vic_rng.lo && w <= vic_rng.hi &&
            (!found || ages_q[victim_set][w] > best_age)) begin
          found      = 1'b1;
          best_age   = ages_q[victim_set][w];
          victim_way = WAY_W'(w);
        end
      end
    end
  end

endmodule

// File: tb/tb_mt_cache_lru.sv
// Directed bench for mt_cache_lru with hand-computed victim expectations.
module tb_mt_cache_lru;
  import mt_cache_lru_pkg::*;

  logic                 clock = 1'b0;
  logic                 reset;
  multithreading_mode_t mt_mode;
  logic                 thread_id;
  logic                 victim_req;
  logic [1:0]           victim_set;
  logic [1:0]           victim_way;
  logic                 update_req;
  logic [1:0]           update_set;
  logic [1:0]           update_way;
  logic                 update_req_mt;
  logic [1:0]           update_set_mt;
  logic [1:0]           update_way_mt;
  logic                 update_thread_mt;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  mt_cache_lru dut (
    .clock            (clock),
    .reset            (reset),
    .mt_mode          (mt_mode),
    .thread_id        (thread_id),
    .victim_req       (victim_req),
    .victim_set       (victim_set),
    .victim_way       (victim_way),
    .update_req       (update_req),
    .update_set       (update_set),
    .update_way       (update_way),
    .update_req_mt    (update_req_mt),
    .update_set_mt    (update_set_mt),
    .update_way_mt    (update_way_mt),
    .update_thread_mt (update_thread_mt)
  );

  task automatic look(input string tag, input logic req, input logic [1:0] set,
                      input logic thr, input logic [1:0] exp);
    victim_req = req;
    victim_set = set;
    thread_id  = thr;
    #1;
    checks++;
    assert (victim_way === exp) else begin
      errors++;
      $error("FAIL %s: victim_way=%0d expected %0d", tag, victim_way, exp);
    end
  endtask

  // One clock edge with the given updates, then idle the update ports.
  task automatic tick(input logic hv, input logic [1:0] hs, input logic [1:0] hw,
                      input logic fv, input logic [1:0] fs, input logic [1:0] fw);
    update_req    = hv;
    update_set    = hs;
    update_way    = hw;
    update_req_mt = fv;
    update_set_mt = fs;
    update_way_mt = fw;
    @(posedge clock);
    #1;
    update_req    = 1'b0;
    update_req_mt = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b0;
    mt_mode = ModeSt;
    thread_id = 1'b0;
    victim_req = 1'b0;
    victim_set = '0;
    update_req = 1'b0;
    update_set = '0;
    update_way = '0;
    update_req_mt = 1'b0;
    update_set_mt = '0;
    update_way_mt = '0;
    update_thread_mt = 1'b0;
    #12;
    look("in_reset_set0", 1'b1, 2'd0, 1'b0, 2'd0);
    reset = 1'b1;
    @(negedge clock);

    // Reset state, ST
    look("rst_st_set0", 1'b1, 2'd0, 1'b0, 2'd0);
    look("rst_st_set3", 1'b1, 2'd3, 1'b0, 2'd0);

    // ST hits in set 0: [0,3,2,1] then [1,0,3,2]
    tick(1'b1, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0);
    look("st_upd_w0", 1'b1, 2'd0, 1'b0, 2'd1);
    tick(1'b1, 2'd0, 2'd1, 1'b0, 2'd0, 2'd0);
    look("st_upd_w1", 1'b1, 2'd0, 1'b0, 2'd2);
    look("no_req_zero", 1'b0, 2'd0, 1'b0, 2'd0);
    look("st_set1_untouched", 1'b1, 2'd1, 1'b0, 2'd0);

    // MT partitioning from reset
    mt_mode = ModeMt;
    do_reset();
    look("mt_rst_t0", 1'b1, 2'd0, 1'b0, 2'd0);
    look("mt_rst_t1", 1'b1, 2'd0, 1'b1, 2'd2);
    tick(1'b1, 2'd0, 2'd2, 1'b0, 2'd0, 2'd0);
    look("mt_upd_w2_t1", 1'b1, 2'd0, 1'b1, 2'd3);
    look("mt_upd_w2_t0", 1'b1, 2'd0, 1'b0, 2'd0);

    // Same-set chained hit + refill: [3,0,2,1] -> [3,1,0,2] -> [0,2,1,3]
    mt_mode = ModeSt;
    do_reset();
    tick(1'b1, 2'd1, 2'd1, 1'b1, 2'd1, 2'd2);
    look("dual_same_set", 1'b1, 2'd1, 1'b0, 2'd0);
    tick(1'b1, 2'd1, 2'd0, 1'b0, 2'd0, 2'd0);
    look("dual_then_w0", 1'b1, 2'd1, 1'b0, 2'd3);

    // Different-set simultaneous updates
    do_reset();
    tick(1'b1, 2'd0, 2'd0, 1'b1, 2'd2, 2'd0);
    look("dual_diff_set0", 1'b1, 2'd0, 1'b0, 2'd1);
    look("dual_diff_set2", 1'b1, 2'd2, 1'b0, 2'd1);
    look("dual_diff_set1", 1'b1, 2'd1, 1'b0, 2'd0);
    look("dual_diff_set3", 1'b1, 2'd3, 1'b0, 2'd0);

    // Asynchronous reset mid-cycle
    tick(1'b1, 2'd3, 2'd0, 1'b0, 2'd0, 2'd0);
    #2;
    reset = 1'b0;
    for (int s = 0; s < 4; s++) begin
      for (int t = 0; t < 2; t++) begin
        look($sformatf("async_rst_s%0d_t%0d", s, t), 1'b1, 2'(s), 1'(t), 2'd0);
      end
    end
    reset = 1'b1;
    @(negedge clock);
    look("post_rst_set0", 1'b1, 2'd0, 1'b0, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
